// File: rtl/led_blink_bank.sv
// Bank of independent LED channels: OFF / ON / BLINK (counter tap) / PWM (8-bit duty).
// Configuration lands in a shadow and is applied at a phase-safe point of the channel counter.
//
// mode   | meaning
// OFF    | led driven 0
// ON     | led driven 1
// BLINK  | led follows counter[tap]
// PWM    | led high while counter[7:0] < duty
module led_blink_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 25,
  parameter int DEF_TAP = 24
) (
  input  logic              clk0_1,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [4:0]        cfg_tap,
  input  logic [7:0]        cfg_duty,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] cfg_pending
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  localparam logic [4:0] TAP_MAX   = 5'(CNT_W - 1);
  localparam logic [4:0] TAP_RESET = 5'(DEF_TAP);
  localparam logic [7:0] DUTY_RESET = 8'd128;

  logic lock_m;
  logic lock_s;

  always_ff @(posedge clk0_1) begin
    if (!rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  logic [4:0] tap_clamped;
  assign tap_clamped = (cfg_tap > TAP_MAX) ? TAP_MAX : cfg_tap;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    mode_t            act_mode;
    logic [4:0]       act_tap;
    logic [7:0]       act_duty;
    mode_t            sh_mode;
    logic [4:0]       sh_tap;
    logic [7:0]       sh_duty;
    logic             pending;
    logic             led_q;

    logic sel;
    logic tap_ones;
    logic blink_bit;
    logic apply_pt;
    logic led_nxt;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign sel = cfg_we && (cfg_ch == 4'(ch));

    always_comb begin
      tap_ones  = 1'b1;
      blink_bit = 1'b0;
      for (int i = 0; i < CNT_W; i++) begin
        if (i <= int'(act_tap) && !cnt[i]) tap_ones = 1'b0;
        if (i == int'(act_tap)) blink_bit = cnt[i];
      end
    end

    always_comb begin
      apply_pt = 1'b0;
      led_nxt  = 1'b0;
      case (act_mode)
        MODE_OFF: begin
          apply_pt = 1'b1;
          led_nxt  = 1'b0;
        end
        MODE_ON: begin
          apply_pt = 1'b1;
          led_nxt  = 1'b1;
        end
        MODE_BLINK: begin
          apply_pt = lock_s && tap_ones;
          led_nxt  = blink_bit;
        end
        MODE_PWM: begin
          apply_pt = lock_s && (cnt[7:0] == 8'hFF);
          led_nxt  = (cnt[7:0] < act_duty);
        end
        default: begin
          apply_pt = 1'b0;
          led_nxt  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk0_1) begin
      if (!rst) begin
        cnt      <= '0;
        act_mode <= MODE_BLINK;
        act_tap  <= TAP_RESET;
        act_duty <= DUTY_RESET;
        sh_mode  <= MODE_BLINK;
        sh_tap   <= TAP_RESET;
        sh_duty  <= DUTY_RESET;
        pending  <= 1'b0;
        led_q    <= 1'b0;
      end else begin
        if (lock_s) cnt <= cnt + 1'b1;

        // Counter is never touched on apply, so the new mode keeps the old phase.
        if (pending && apply_pt) begin
          act_mode <= sh_mode;
          act_tap  <= sh_tap;
          act_duty <= sh_duty;
        end

        if (sel) begin
          sh_mode <= mode_t'(cfg_mode);
          sh_tap  <= tap_clamped;
          sh_duty <= cfg_duty;
          pending <= 1'b1;
        end else if (apply_pt) begin
          pending <= 1'b0;
        end

        // Counter-driven modes freeze with the counter while unlocked.
        if (lock_s || act_mode == MODE_OFF || act_mode == MODE_ON) led_q <= led_nxt;
      end
    end

    assign led[ch]         = led_q;
    assign cfg_pending[ch] = pending;
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Randomized bench for led_blink_bank, compared every cycle against an arithmetic channel model.
module tb_led_blink_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 9;
  localparam int DEF_TAP = 3;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk0_1 = 1'b0;
  logic              rst = 1'b0;
  logic              pll_locked = 1'b1;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [4:0]        cfg_tap = '0;
  logic [7:0]        cfg_duty = '0;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] cfg_pending;

  led_blink_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_TAP(DEF_TAP)) dut (
    .clk0_1     (clk0_1),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_tap    (cfg_tap),
    .cfg_duty   (cfg_duty),
    .led        (led),
    .cfg_pending(cfg_pending)
  );

  always #5 clk0_1 = ~clk0_1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: modes 0 OFF, 1 ON, 2 BLINK, 3 PWM
  int m_lock_pipe[2];
  int m_cnt[NUM_CH];
  int m_amode[NUM_CH], m_atap[NUM_CH], m_aduty[NUM_CH];
  int m_smode[NUM_CH], m_stap[NUM_CH], m_sduty[NUM_CH];
  int m_pend[NUM_CH], m_led[NUM_CH];

  function automatic void model_edge();
    int locked;
    int period;
    int due;
    int nled;
    locked = m_lock_pipe[1];
    if (!rst) begin
      m_lock_pipe[0] = 0;
      m_lock_pipe[1] = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0; m_led[c] = 0; m_pend[c] = 0;
        m_amode[c] = 2; m_atap[c] = DEF_TAP; m_aduty[c] = 128;
        m_smode[c] = 2; m_stap[c] = DEF_TAP; m_sduty[c] = 128;
      end
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      period = 2 << m_atap[c];
      case (m_amode[c])
        0: begin due = 1; nled = 0; end
        1: begin due = 1; nled = 1; end
        2: begin
          due  = locked && ((m_cnt[c] % period) == period - 1);
          nled = (m_cnt[c] / (1 << m_atap[c])) % 2;
        end
        default: begin
          due  = locked && ((m_cnt[c] % 256) == 255);
          nled = (m_cnt[c] % 256) < m_aduty[c];
        end
      endcase
      if (locked || m_amode[c] < 2) m_led[c] = nled;
      if (locked) m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
      if (m_pend[c] && due) begin
        m_amode[c] = m_smode[c]; m_atap[c] = m_stap[c]; m_aduty[c] = m_sduty[c];
        m_pend[c] = 0;
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        m_smode[c] = int'(cfg_mode);
        m_stap[c]  = (int'(cfg_tap) > CNT_W - 1) ? CNT_W - 1 : int'(cfg_tap);
        m_sduty[c] = int'(cfg_duty);
        m_pend[c]  = 1;
      end
    end
    m_lock_pipe[1] = m_lock_pipe[0];
    m_lock_pipe[0] = int'(pll_locked);
  endfunction

  task automatic step(input string tag);
    logic [NUM_CH-1:0] exp_led;
    logic [NUM_CH-1:0] exp_pend;
    @(posedge clk0_1);
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_led[c]  = m_led[c][0];
      exp_pend[c] = m_pend[c][0];
    end
    chk({tag, ".led"}, 32'(led), 32'(exp_led));
    chk({tag, ".pend"}, 32'(cfg_pending), 32'(exp_pend));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic write(input string tag, input int ch, input int mode, input int tap, input int duty);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_mode = 2'(mode); cfg_tap = 5'(tap); cfg_duty = 8'(duty);
    step(tag);
    cfg_we = 1'b0;
  endtask

  initial begin
    int hold;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;

    rst = 1'b0;
    run("reset", 3);
    rst = 1'b1;
    run("start", 40);

    write("pwm64", 1, 3, 0, 64);
    run("pwm64", 600);

    write("on_off", 2, 1, 0, 0);
    write("on_off", 2, 0, 0, 0);
    run("on_off", 30);

    pll_locked = 1'b0;
    run("unlock", 20);
    pll_locked = 1'b1;
    run("relock", 40);

    write("ch7", 7, 1, 0, 0);
    write("tap31", 3, 2, 31, 0);
    run("tap31", 1100);

    write("rst_pend", 0, 3, 0, 10);
    rst = 1'b0;
    step("rst_pend");
    rst = 1'b1;
    run("after_rst", 30);

    // Reset coinciding with a write: reset wins
    rst = 1'b0;
    write("rst_we", 0, 1, 0, 0);
    rst = 1'b1;
    run("rst_we", 20);

    hold = 0;
    for (int i = 0; i < 20000; i++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 299) == 0) begin
        pll_locked = ~pll_locked;
        hold = $urandom_range(1, 40);
      end else pll_locked = 1'b1;
      rst = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 15) == 0)
        write("rand", $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 31), $urandom_range(0, 255));
      else
        step("rand");
    end
    rst = 1'b1;
    pll_locked = 1'b1;
    run("tail", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
